// File: rtl/pipe_skid_stage.sv
// Pipeline register with one-entry skid buffer; out_* driven straight from the main register.
// Latency 1 cycle; in_ready is registered (!skid valid), so out_ready never reaches it combinationally.
module pipe_skid_stage #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 128,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Bit 0 is main-valid, bit 1 is skid-valid; 2'b10 is the unreachable encoding.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [CTRL_W-1:0]  m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic [CTRL_W-1:0]  s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]  s_data_q, s_data_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic send;

    assign m_valid   = state_q[0];
    assign s_valid   = state_q[1];
    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign stall_cnt = stall_cnt_q;

    assign accept = in_valid && in_ready;
    assign send   = m_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;

        if (flush) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            if (CLEAR_DATA != 0) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && send) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (accept) begin
                        state_d  = ST_FULL;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (send) begin
                        // Bubbles must present all-zero control downstream.
                        state_d  = ST_EMPTY;
                        m_ctrl_d = '0;
                        if (CLEAR_DATA != 0) begin
                            m_data_d = '0;
                        end
                    end
                end
                ST_FULL: begin
                    if (send) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        s_ctrl_d = '0;
                        if (CLEAR_DATA != 0) begin
                            s_data_d = '0;
                        end
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    m_ctrl_d = '0;
                    s_ctrl_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            m_ctrl_q    <= '0;
            m_data_q    <= '0;
            s_ctrl_q    <= '0;
            s_data_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_ctrl_q    <= m_ctrl_d;
            m_data_q    <= m_data_d;
            s_ctrl_q    <= s_ctrl_d;
            s_data_q    <= s_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef SIM
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (state_q != 2'b10);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench: table of per-cycle vectors plus hand sequences for flush, saturation and async reset.
module tb_pipe_skid_stage;

    localparam int CW = 16;
    localparam int DW = 32;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready,  in_ready0;
    logic          out_valid, out_valid0;
    logic [CW-1:0] out_ctrl,  out_ctrl0;
    logic [DW-1:0] out_data,  out_data0;
    logic [NW-1:0] stall_cnt, stall_cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(0), .CNT_W(NW)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .stall_cnt(stall_cnt0)
    );

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic          ordy;
        logic          ev;
        logic [CW-1:0] ec;
        logic          eir;
        logic [NW-1:0] es;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DW-1:0] mk(input logic [CW-1:0] c);
        return {c, ~c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic [CW-1:0] ic, input logic ordy,
                       input logic ev, input logic [CW-1:0] ec, input logic eir,
                       input logic [NW-1:0] es);
        vec_t v;
        v.iv = iv; v.ic = ic; v.ordy = ordy;
        v.ev = ev; v.ec = ec; v.eir = eir; v.es = es;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = mk(ic);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Stream 1..8 at full throughput, then drain.
        for (int k = 1; k <= 8; k++) add(1, CW'(k), 1, 1, CW'(k), 1, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        // Back-pressure: 6 lands in skid, 7 held upstream, three stalled cycles.
        add(1, 5, 1, 1, 5, 1, 0);
        add(1, 6, 0, 1, 5, 0, 1);
        add(1, 7, 0, 1, 5, 0, 2);
        add(1, 7, 0, 1, 5, 0, 3);
        add(1, 7, 1, 1, 6, 1, 3);
        add(1, 7, 1, 1, 7, 1, 3);
        add(0, 0, 1, 0, 0, 1, 3);
        // Alternating bubbles.
        add(1, 9, 1, 1, 9, 1, 3);
        add(0, 0, 1, 0, 0, 1, 3);
        add(1, 10, 1, 1, 10, 1, 3);
        add(0, 0, 1, 0, 0, 1, 3);

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_ctrl",  64'(out_ctrl),  64'(0));
        check("reset_out_data",  64'(out_data),  64'(0));
        check("reset_in_ready",  64'(in_ready),  64'(1));
        check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ic, vecs[i].ordy, 0);
            cycle();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_out_ctrl", i),  64'(out_ctrl),  64'(vecs[i].ec));
            check($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].eir));
            check($sformatf("vec%0d_stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].es));
            check($sformatf("vec%0d_out_data", i),  64'(out_data),
                  64'(vecs[i].ev ? mk(vecs[i].ec) : '0));
        end

        // Flush in FULL with a simultaneous offer.
        drive(1, 16'hA, 0, 0);
        cycle();
        drive(1, 16'hB, 0, 0);
        cycle();
        check("flush_pre_in_ready", 64'(in_ready), 64'(0));
        check("flush_pre_out_ctrl", 64'(out_ctrl), 64'(16'hA));
        drive(1, 16'hC, 0, 1);
        cycle();
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_out_ctrl",  64'(out_ctrl),  64'(0));
        check("flush_in_ready",  64'(in_ready),  64'(1));
        check("flush_out_data_clear", 64'(out_data),  64'(0));
        check("flush_out_data_keep",  64'(out_data0), 64'(mk(16'hA)));
        check("flush_out_ctrl_keepdut", 64'(out_ctrl0), 64'(0));
        drive(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("flush_after%0d_out_valid", k), 64'(out_valid), 64'(0));
            check($sformatf("flush_after%0d_out_ctrl", k),  64'(out_ctrl),  64'(0));
        end

        // Counter saturation from a fresh reset.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("sat_start", 64'(stall_cnt), 64'(0));
        drive(1, 16'h33, 0, 0);
        cycle();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle();
        check("sat_stall_cnt", 64'(stall_cnt), 64'(15));
        check("sat_out_ctrl",  64'(out_ctrl),  64'(16'h33));
        drive(0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0);
        check("sat_flush_out_valid", 64'(out_valid), 64'(0));
        check("sat_flush_stall_cnt", 64'(stall_cnt), 64'(15));

        // Asynchronous reset while FULL, between clock edges.
        drive(1, 16'h44, 0, 0);
        cycle();
        drive(1, 16'h55, 0, 0);
        cycle();
        check("arst_pre_in_ready", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid),  64'(0));
        check("arst_out_ctrl",  64'(out_ctrl),   64'(0));
        check("arst_stall_cnt", 64'(stall_cnt),  64'(0));
        check("arst_in_ready",  64'(in_ready),   64'(1));
        check("arst_out_data0", 64'(out_data0),  64'(0));
        drive(0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("arst_after_out_valid", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
